// File: rtl/led_pkg.sv
// Shared mode encoding and timing defaults for the LED scan/debounce blocks.
package led_pkg;

  typedef enum logic {
    MODE_AUTO = 1'b0,
    MODE_MAN  = 1'b1
  } mode_e;

  // 1 kHz channel slot at a 100 MHz system clock
  localparam int unsigned DEFAULT_DIV = 100000;

endpackage

// File: rtl/led_mux_scan_tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clocks, clearable to restart a slot.
module tick_gen
  import led_pkg::*;
#(
  parameter int unsigned DIV = DEFAULT_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_mux_scan.sv
// Time-division N:1 scan of switch channels onto one LED, with auto frame scan or manual select.
module led_mux_scan
  import led_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  parameter int unsigned DIV  = DEFAULT_DIV
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CH-1:0]           sw,
  input  logic                      mode,
  input  logic [$clog2(N_CH)-1:0]   man_sel,
  output logic                      led,
  output logic [$clog2(N_CH)-1:0]   sel,
  output logic                      frame_start
);

  localparam int unsigned SEL_W = $clog2(N_CH);
  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(N_CH - 1);

  mode_e           mode_i;
  mode_e           mode_q;
  logic [N_CH-1:0] frame;
  logic            tick;
  logic            clr;

  assign mode_i = mode_e'(mode);
  // Slot counter restarts while in manual and on the manual->auto return edge.
  assign clr    = (mode_i == MODE_MAN) || (mode_q == MODE_MAN);

  tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_AUTO;
      sel         <= '0;
      frame       <= '0;
      frame_start <= 1'b0;
    end else begin
      mode_q      <= mode_i;
      frame_start <= 1'b0;
      if (mode_i == MODE_MAN) begin
        sel   <= man_sel;
        frame <= sw;
      end else if (mode_q == MODE_MAN) begin
        sel         <= '0;
        frame       <= sw;
        frame_start <= 1'b1;
      end else if (tick) begin
        if (sel == SEL_MAX) begin
          sel         <= '0;
          frame       <= sw;
          frame_start <= 1'b1;
        end else begin
          sel <= sel + 1'b1;
        end
      end
    end
  end

  assign led = frame[sel];

endmodule

// File: tb/tb_led_mux_scan.sv
// Directed bench for led_mux_scan with N_CH=4, DIV=4 (4-cycle slots, 16-cycle frames).
module tb_led_mux_scan;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw;
  logic       mode;
  logic [1:0] man_sel;
  logic       led;
  logic [1:0] sel;
  logic       frame_start;

  int checks = 0;
  int errors = 0;

  led_mux_scan #(.N_CH(4), .DIV(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw          (sw),
    .mode        (mode),
    .man_sel     (man_sel),
    .led         (led),
    .sel         (sel),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input int e_sel, input int e_led, input int e_fs);
    chk({tag, ".sel"}, 32'(sel), 32'(e_sel));
    chk({tag, ".led"}, 32'(led), 32'(e_led));
    chk({tag, ".frame_start"}, 32'(frame_start), 32'(e_fs));
  endtask

  logic [3:0] exp_frame;

  initial begin
    rst_n   = 1'b0;
    mode    = 1'b0;
    sw      = 4'b1010;
    man_sel = 2'd0;

    // 1: reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      step();
      chk_outs("reset_hold", 0, 0, 0);
    end
    rst_n = 1'b1;

    // first frame after reset shows zeros
    for (int c = 0; c < 16; c++) begin
      chk_outs("frame0", c / 4, 0, 0);
      step();
    end

    // 2: second frame latched 1010, pulse exactly at cycle 16 and 32
    exp_frame = 4'b1010;
    for (int c = 0; c < 16; c++) begin
      chk_outs("frame1", c / 4, int'(exp_frame[c / 4]), (c == 0) ? 1 : 0);
      step();
    end

    // 3: mid-frame switch change is not visible until next wrap
    for (int c = 0; c < 4; c++) begin
      chk_outs("frame2_s0", 0, 0, (c == 0) ? 1 : 0);
      step();
    end
    sw = 4'b0101;
    for (int c = 4; c < 16; c++) begin
      chk_outs("frame2_mid", c / 4, int'(exp_frame[c / 4]), 0);
      step();
    end
    exp_frame = 4'b0101;
    for (int c = 0; c < 16; c++) begin
      chk_outs("frame3", c / 4, int'(exp_frame[c / 4]), (c == 0) ? 1 : 0);
      if (c < 15) step();
    end

    // 4: manual select
    mode    = 1'b1;
    man_sel = 2'd2;
    sw      = 4'b0100;
    step();
    chk_outs("man_sel2", 2, 1, 0);
    sw = 4'b0000;
    step();
    chk_outs("man_sw0", 2, 0, 0);
    step();
    chk_outs("man_hold", 2, 0, 0);

    // 5: manual -> auto restarts a frame with a pulse
    sw   = 4'b0001;
    mode = 1'b0;
    step();
    chk_outs("m2a_edge", 0, 1, 1);
    for (int i = 1; i < 4; i++) begin
      step();
      chk_outs("m2a_slot0", 0, 1, 0);
    end
    step();
    chk_outs("m2a_slot1", 1, 0, 0);

    // 6: async reset with sel=3, cnt=2
    for (int i = 0; i < 10; i++) step();
    chk("pre_rst.sel", 32'(sel), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("async_rst", 0, 0, 0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk_outs("post_rst_s0", 0, 0, 0);
      step();
    end
    chk_outs("post_rst_s1", 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
